usb_out_txn_ctrl: RTL
=====================

USB_OUT_TXN_CTRL -- requirements
Module: usb_out_txn_ctrl

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port req_valid  input  1  host requests an OUT transaction.
REQ-004 SHALL have port req_ready  output  1  controller can accept a request.
REQ-005 SHALL have port req_addr  input  7  target device address.
REQ-006 SHALL have port req_endp  input  4  target endpoint.
REQ-007 SHALL have port req_data  input  64  payload.
REQ-008 SHALL have port pkt_avail  output  1  one-cycle launch strobe to the bit stream encoder.
REQ-009 SHALL have port pid_in  output  8  PID to the encoder.
REQ-010 SHALL have port addr_in  output  7  address to the encoder.
REQ-011 SHALL have port endp_in  output  4  endpoint to the encoder.
REQ-012 SHALL have port data_in  output  64  payload to the encoder.
REQ-013 SHALL have port enc_last  input  1  encoder last-bit indication.
REQ-014 SHALL have port hs_valid  input  1  one-cycle strobe from the receiver carrying a decoded handshake.
REQ-015 SHALL have port hs_pid  input  8  received handshake PID.
REQ-016 SHALL have port done  output  1  one-cycle transaction-complete pulse.
REQ-017 SHALL have port status  output  2  result, valid with done: 0 OK, 1 STALL, 2 ERROR.

Function
REQ-018 SHALL implement FSM states IDLE, TOKEN, TOKEN_WAIT, GAP, DATA, DATA_WAIT, HS_WAIT, FINISH.
REQ-019 SHALL drive req_ready=1 only in IDLE; req_valid&&req_ready SHALL capture addr/endp/data and enter TOKEN.
REQ-020 SHALL, in TOKEN, assert pkt_avail for exactly one cycle with pid_in=E1 (OUT) and captured addr/endp, then enter TOKEN_WAIT.
REQ-021 SHALL hold pid_in/addr_in/endp_in/data_in stable from pkt_avail until enc_last is sampled high.
REQ-022 SHALL, on enc_last in TOKEN_WAIT, enter GAP and wait IPG_CYCLES=4 cycles, then enter DATA.
REQ-023 SHALL, in DATA, pulse pkt_avail with pid_in=C3 (DATA0) or 4B (DATA1) per toggle[req_endp] and data_in=captured payload.
REQ-024 SHALL, on enc_last in DATA_WAIT, enter HS_WAIT with 8-bit timeout counter cleared.
REQ-025 SHALL, in HS_WAIT, on hs_valid with hs_pid=D2 (ACK): flip toggle[endp], status=OK, enter FINISH.
REQ-026 SHALL, on hs_valid with hs_pid=1E (STALL): status=STALL, no retry, toggle unchanged, enter FINISH.
REQ-027 SHALL treat NAK (5A), any other hs_pid, or counter reaching 255 without hs_valid as a failed attempt.
REQ-028 SHALL, on a failed attempt with retry_cnt<MAX_RETRY=3, increment retry_cnt and enter GAP, then restart at TOKEN (not DATA).
REQ-029 SHALL, on a failed attempt with retry_cnt=3, set status=ERROR and enter FINISH.
REQ-030 SHALL, in FINISH, assert done for one cycle, clear retry_cnt, and return to IDLE.
REQ-031 SHALL give hs_valid priority over timeout when both occur in the same cycle.
REQ-032 SHALL ignore hs_valid outside HS_WAIT and enc_last outside TOKEN_WAIT/DATA_WAIT.
REQ-033 SHALL keep a 16-entry per-endpoint data-toggle array, independent per endpoint.

Reset
REQ-034 SHALL on rst_n low, regardless of state: FSM to IDLE; req_ready=0 during reset and 1 after; pkt_avail=0, done=0, status=0, pid_in/addr_in/endp_in/data_in=0, toggles=0, counters=0.
REQ-035 SHALL abandon any in-flight transaction on reset without asserting done.

Structure
REQ-036 SHALL take PID constants, IPG_CYCLES, MAX_RETRY, HS_TIMEOUT and the state and status enums from shared package usb_pkg.
REQ-037 SHALL implement the gap/timeout counter as sub-module usb_cycle_timer (load, enable, terminal-count flag).

Verification
REQ-038 SHALL verify: request addr=5, endp=4, data=CAFEBABEDEADBEEF, ACK -> pid E1 then C3, gap of 4 cycles, done with status=0, toggle[4]=1.
REQ-039 SHALL verify: second request to endp 4 with ACK -> DATA pid 4B; then request to endp 2 -> DATA pid C3.
REQ-040 SHALL verify: NAK twice then ACK -> 3 OUT tokens, done once, status=0.
REQ-041 SHALL verify: no handshake for all attempts -> 4 OUT tokens, each DATA wait 255 cycles, done with status=2, toggle unchanged.
REQ-042 SHALL verify: STALL reply -> done with status=1, no retry token, toggle unchanged.
REQ-043 SHALL verify: rst_n low during DATA_WAIT -> outputs at reset values immediately, no done pulse, req_ready=1 one cycle after release.

Source files
------------

// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared USB PIDs, timing constants and OUT-transaction enums
package usb_pkg;

  localparam logic [7:0] PID_OUT   = 8'hE1;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_STALL = 8'h1E;

  localparam int IPG_CYCLES = 4;
  localparam int MAX_RETRY  = 3;
  localparam int HS_TIMEOUT = 255;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TOKEN,
    ST_TOKEN_WAIT,
    ST_GAP,
    ST_DATA,
    ST_DATA_WAIT,
    ST_HS_WAIT,
    ST_FINISH
  } state_e;

  typedef enum logic [1:0] {
    STATUS_OK    = 2'd0,
    STATUS_STALL = 2'd1,
    STATUS_ERROR = 2'd2
  } status_e;

  function automatic logic [7:0] data_pid(input logic toggle);
    return toggle ? PID_DATA1 : PID_DATA0;
  endfunction

endpackage

// File: rtl/usb_cycle_timer.sv
// rtl/usb_cycle_timer.sv - up-counter with clear-load, enable and terminal-count flag
module usb_cycle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // tc marks the last of 'limit' cycles counted from the clearing load
  assign tc = (cnt_q == (limit - W'(1)));

endmodule

// File: rtl/usb_out_txn_ctrl.sv
// rtl/usb_out_txn_ctrl.sv - USB host OUT transaction sequencer (token, data, handshake, retry)
module usb_out_txn_ctrl
  import usb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [6:0]  req_addr,
  input  logic [3:0]  req_endp,
  input  logic [63:0] req_data,
  output logic        pkt_avail,
  output logic [7:0]  pid_in,
  output logic [6:0]  addr_in,
  output logic [3:0]  endp_in,
  output logic [63:0] data_in,
  input  logic        enc_last,
  input  logic        hs_valid,
  input  logic [7:0]  hs_pid,
  output logic        done,
  output logic [1:0]  status
);

  state_e      state_q, state_d;
  status_e     status_q, status_d;
  logic        req_ready_q, req_ready_d;
  logic        pkt_avail_q, pkt_avail_d;
  logic        done_q, done_d;
  logic [7:0]  pid_q, pid_d;
  logic [6:0]  addr_q, addr_d;
  logic [3:0]  endp_q, endp_d;
  logic [63:0] data_q, data_d;
  logic [15:0] toggle_q, toggle_d;
  logic [1:0]  retry_q, retry_d;
  logic        resend_q, resend_d;

  logic        tmr_load, tmr_en, tmr_tc, fail;
  logic [7:0]  tmr_limit;

  assign tmr_en    = (state_q == ST_GAP) || (state_q == ST_HS_WAIT);
  assign tmr_limit = (state_q == ST_GAP) ? 8'(IPG_CYCLES) : 8'(HS_TIMEOUT);

  usb_cycle_timer #(.W(8)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tmr_load),
    .en    (tmr_en),
    .limit (tmr_limit),
    .tc    (tmr_tc)
  );

  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    pkt_avail_d = 1'b0;
    done_d      = 1'b0;
    pid_d       = pid_q;
    addr_d      = addr_q;
    endp_d      = endp_q;
    data_d      = data_q;
    toggle_d    = toggle_q;
    retry_d     = retry_q;
    resend_d    = resend_q;
    tmr_load    = 1'b0;
    fail        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          addr_d      = req_addr;
          endp_d      = req_endp;
          data_d      = req_data;
          pid_d       = PID_OUT;
          pkt_avail_d = 1'b1;
          state_d     = ST_TOKEN;
        end
      end
      ST_TOKEN:      state_d = ST_TOKEN_WAIT;
      ST_TOKEN_WAIT: begin
        if (enc_last) begin
          tmr_load = 1'b1;
          state_d  = ST_GAP;
        end
      end
      ST_GAP: begin
        // a retry re-sends the OUT token before the data packet
        if (tmr_tc) begin
          pkt_avail_d = 1'b1;
          if (resend_q) begin
            resend_d = 1'b0;
            pid_d    = PID_OUT;
            state_d  = ST_TOKEN;
          end else begin
            pid_d    = data_pid(toggle_q[endp_q]);
            state_d  = ST_DATA;
          end
        end
      end
      ST_DATA:       state_d = ST_DATA_WAIT;
      ST_DATA_WAIT: begin
        if (enc_last) begin
          tmr_load = 1'b1;
          state_d  = ST_HS_WAIT;
        end
      end
      ST_HS_WAIT: begin
        if (hs_valid) begin
          if (hs_pid == PID_ACK) begin
            toggle_d[endp_q] = ~toggle_q[endp_q];
            status_d         = STATUS_OK;
            done_d           = 1'b1;
            state_d          = ST_FINISH;
          end else if (hs_pid == PID_STALL) begin
            status_d = STATUS_STALL;
            done_d   = 1'b1;
            state_d  = ST_FINISH;
          end else begin
            fail = 1'b1;
          end
        end else if (tmr_tc) begin
          fail = 1'b1;
        end
      end
      ST_FINISH: begin
        retry_d = 2'd0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (fail) begin
      if (retry_q < 2'(MAX_RETRY)) begin
        retry_d  = retry_q + 2'd1;
        resend_d = 1'b1;
        tmr_load = 1'b1;
        state_d  = ST_GAP;
      end else begin
        status_d = STATUS_ERROR;
        done_d   = 1'b1;
        state_d  = ST_FINISH;
      end
    end
  end

  assign req_ready_d = (state_d == ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      status_q    <= STATUS_OK;
      req_ready_q <= 1'b0;
      pkt_avail_q <= 1'b0;
      done_q      <= 1'b0;
      pid_q       <= '0;
      addr_q      <= '0;
      endp_q      <= '0;
      data_q      <= '0;
      toggle_q    <= '0;
      retry_q     <= '0;
      resend_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      req_ready_q <= req_ready_d;
      pkt_avail_q <= pkt_avail_d;
      done_q      <= done_d;
      pid_q       <= pid_d;
      addr_q      <= addr_d;
      endp_q      <= endp_d;
      data_q      <= data_d;
      toggle_q    <= toggle_d;
      retry_q     <= retry_d;
      resend_q    <= resend_d;
    end
  end

  assign req_ready = req_ready_q;
  assign pkt_avail = pkt_avail_q;
  assign done      = done_q;
  assign status    = status_q;
  assign pid_in    = pid_q;
  assign addr_in   = addr_q;
  assign endp_in   = endp_q;
  assign data_in   = data_q;

endmodule
